// File: rtl/noise_channel_ctrl.sv
// Control sequencer for the noise voice: NR41-NR44 state, length counter, volume envelope, trigger.
// Optional `define NOISE_CTRL_STATUS_EN adds a registered status[7:0] debug output.
module noise_channel_ctrl #(
    parameter int LEN_BITS = 6,
    parameter int ENV_STEP = 7
) (
    input  logic       frequency_timer_clock,
    input  logic       reset,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    input  logic       frame_tick,
    input  logic [2:0] frame_step,
    output logic [7:0] nr43_q,
    output logic       lfsr_reload,
    output logic       channel_on,
    output logic       dac_on,
    output logic [3:0] volume
`ifdef NOISE_CTRL_STATUS_EN
    ,
    output logic [7:0] status
`endif
);

    localparam logic [LEN_BITS:0] LEN_FULL = {1'b1, {LEN_BITS{1'b0}}};

    logic [7:0]        nr42_q;
    logic              length_en;
    logic [LEN_BITS:0] len_cnt;
    logic [2:0]        env_timer;
    logic              env_active;
    logic [3:0]        volume_reg;

    logic wr_nr41;
    logic wr_nr42;
    logic wr_nr43;
    logic wr_nr44;
    logic trigger;
    logic len_tick;
    logic env_tick;

    assign wr_nr41 = reg_we && (reg_addr == 2'd0);
    assign wr_nr42 = reg_we && (reg_addr == 2'd1);
    assign wr_nr43 = reg_we && (reg_addr == 2'd2);
    assign wr_nr44 = reg_we && (reg_addr == 2'd3);
    assign trigger = wr_nr44 && reg_wdata[7];

    assign len_tick = frame_tick && !frame_step[0] && length_en && (len_cnt != '0);
    assign env_tick = frame_tick && (frame_step == 3'(ENV_STEP)) &&
                      (nr42_q[2:0] != 3'd0) && env_active;

    assign dac_on = (nr42_q[7:3] != 5'd0);
    assign volume = channel_on ? volume_reg : 4'd0;

    // Same-cycle register writes win over frame ticks only for the state they touch.
    always_ff @(posedge frequency_timer_clock) begin
        if (reset) begin
            nr42_q      <= 8'd0;
            nr43_q      <= 8'd0;
            length_en   <= 1'b0;
            len_cnt     <= '0;
            env_timer   <= 3'd0;
            env_active  <= 1'b0;
            volume_reg  <= 4'd0;
            channel_on  <= 1'b0;
            lfsr_reload <= 1'b0;
        end else begin
            lfsr_reload <= trigger;

            if (wr_nr42) nr42_q <= reg_wdata;
            if (wr_nr43) nr43_q <= reg_wdata;
            if (wr_nr44) length_en <= reg_wdata[6];

            if (wr_nr41) begin
                len_cnt <= LEN_FULL - {1'b0, reg_wdata[LEN_BITS-1:0]};
            end else if (trigger) begin
                if (len_cnt == '0) len_cnt <= LEN_FULL;
            end else if (len_tick) begin
                len_cnt <= len_cnt - 1'b1;
            end

            if (trigger) begin
                volume_reg <= nr42_q[7:4];
                env_timer  <= nr42_q[2:0];
                env_active <= 1'b1;
            end else if (env_tick && !wr_nr42) begin
                // A timer left at 0 by a period-0 trigger behaves as if it just expired.
                if (env_timer <= 3'd1) begin
                    env_timer <= nr42_q[2:0];
                    if (nr42_q[3]) begin
                        if (volume_reg == 4'hF) env_active <= 1'b0;
                        else                    volume_reg <= volume_reg + 4'd1;
                    end else begin
                        if (volume_reg == 4'h0) env_active <= 1'b0;
                        else                    volume_reg <= volume_reg - 4'd1;
                    end
                end else begin
                    env_timer <= env_timer - 3'd1;
                end
            end

            if (wr_nr42 && (reg_wdata[7:3] == 5'd0)) begin
                channel_on <= 1'b0;
            end else if (trigger) begin
                channel_on <= dac_on;
            end else if (len_tick && !wr_nr41 && (len_cnt == {{LEN_BITS{1'b0}}, 1'b1})) begin
                channel_on <= 1'b0;
            end
        end
    end

`ifdef NOISE_CTRL_STATUS_EN
    always_ff @(posedge frequency_timer_clock) begin
        if (reset) status <= 8'd0;
        else       status <= {channel_on, env_active, length_en, len_cnt[4:0]};
    end
`endif

endmodule

// File: tb/tb_noise_channel_ctrl.sv
// Directed self-checking bench for noise_channel_ctrl with hand-computed expectations.
module tb_noise_channel_ctrl;

    logic       frequency_timer_clock;
    logic       reset;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       frame_tick;
    logic [2:0] frame_step;
    logic [7:0] nr43_q;
    logic       lfsr_reload;
    logic       channel_on;
    logic       dac_on;
    logic [3:0] volume;
`ifdef NOISE_CTRL_STATUS_EN
    logic [7:0] status;
`endif

    int vectors;
    int miscompares;

    noise_channel_ctrl dut (
        .frequency_timer_clock(frequency_timer_clock),
        .reset(reset),
        .reg_we(reg_we),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .frame_tick(frame_tick),
        .frame_step(frame_step),
        .nr43_q(nr43_q),
        .lfsr_reload(lfsr_reload),
        .channel_on(channel_on),
        .dac_on(dac_on),
        .volume(volume)
`ifdef NOISE_CTRL_STATUS_EN
        ,
        .status(status)
`endif
    );

    initial frequency_timer_clock = 1'b0;
    always #5 frequency_timer_clock = ~frequency_timer_clock;

    // Drives one cycle of inputs, then leaves the bench 1 time unit past the sampling edge.
    task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [7:0] data,
                                 input logic tick, input logic [2:0] step);
        reg_we     = we;
        reg_addr   = addr;
        reg_wdata  = data;
        frame_tick = tick;
        frame_step = step;
        @(posedge frequency_timer_clock);
        #1;
        reg_we     = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        reg_we      = 1'b0;
        reg_addr    = 2'd0;
        reg_wdata   = 8'd0;
        frame_tick  = 1'b0;
        frame_step  = 3'd0;

        // Reset and idle
        applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        reset = 1'b0;
        checkOutput("rst_nr43", nr43_q, 8'h00);
        checkOutput("rst_reload", {7'd0, lfsr_reload}, 8'd0);
        checkOutput("rst_chan", {7'd0, channel_on}, 8'd0);
        checkOutput("rst_dac", {7'd0, dac_on}, 8'd0);
        checkOutput("rst_vol", {4'd0, volume}, 8'd0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 8'h00, 1, 7);
        checkOutput("idle_chan", {7'd0, channel_on}, 8'd0);
        checkOutput("idle_vol", {4'd0, volume}, 8'd0);

        // Length expiry after two even-step ticks
        applyStimulus(1, 1, 8'hF0, 0, 0);
        checkOutput("t2_dac", {7'd0, dac_on}, 8'd1);
        applyStimulus(1, 0, 8'h3E, 0, 0);
        applyStimulus(1, 3, 8'hC0, 0, 0);
        checkOutput("t2_reload", {7'd0, lfsr_reload}, 8'd1);
        checkOutput("t2_chan_on", {7'd0, channel_on}, 8'd1);
        checkOutput("t2_vol", {4'd0, volume}, 8'd15);
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("t2_reload_off", {7'd0, lfsr_reload}, 8'd0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("t2_chan_len1", {7'd0, channel_on}, 8'd1);
        applyStimulus(0, 0, 8'h00, 1, 1);
        checkOutput("t2_odd_step", {7'd0, channel_on}, 8'd1);
        applyStimulus(0, 0, 8'h00, 1, 2);
        checkOutput("t2_chan_off", {7'd0, channel_on}, 8'd0);
        checkOutput("t2_vol_off", {4'd0, volume}, 8'd0);

        // Envelope down from 8, period 1
        applyStimulus(1, 1, 8'h81, 0, 0);
        applyStimulus(1, 3, 8'h80, 0, 0);
        checkOutput("t3_chan", {7'd0, channel_on}, 8'd1);
        checkOutput("t3_vol8", {4'd0, volume}, 8'd8);
        applyStimulus(0, 0, 8'h00, 1, 7);
        checkOutput("t3_vol7", {4'd0, volume}, 8'd7);
        applyStimulus(0, 0, 8'h00, 1, 3);
        checkOutput("t3_step3", {4'd0, volume}, 8'd7);
        for (int v = 6; v >= 0; v--) begin
            applyStimulus(0, 0, 8'h00, 1, 7);
            checkOutput("t3_down", {4'd0, volume}, 8'(v));
        end
        applyStimulus(0, 0, 8'h00, 1, 7);
        applyStimulus(0, 0, 8'h00, 1, 7);
        checkOutput("t3_floor", {4'd0, volume}, 8'd0);
        checkOutput("t3_chan_keep", {7'd0, channel_on}, 8'd1);

        // Envelope up saturates at 15
        applyStimulus(1, 1, 8'hF9, 0, 0);
        applyStimulus(1, 3, 8'h80, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 7);
        applyStimulus(0, 0, 8'h00, 1, 7);
        checkOutput("t3_ceiling", {4'd0, volume}, 8'd15);

        // Period 0 freezes the envelope
        applyStimulus(1, 1, 8'h90, 0, 0);
        applyStimulus(1, 3, 8'h80, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 7);
        checkOutput("t3_frozen", {4'd0, volume}, 8'd9);

        // NR43 write with envelope tick: both apply; NR42 write discards the tick
        applyStimulus(1, 1, 8'hA1, 0, 0);
        applyStimulus(1, 3, 8'h80, 0, 0);
        checkOutput("t6_vol10", {4'd0, volume}, 8'd10);
        applyStimulus(1, 2, 8'h5B, 1, 7);
        checkOutput("t6_nr43", nr43_q, 8'h5B);
        checkOutput("t6_env_untouched", {4'd0, volume}, 8'd9);
        applyStimulus(1, 1, 8'hA1, 1, 7);
        checkOutput("t6_env_discard", {4'd0, volume}, 8'd9);

        // DAC off while active, then trigger with DAC off
        applyStimulus(1, 1, 8'h00, 0, 0);
        checkOutput("t4_chan_drop", {7'd0, channel_on}, 8'd0);
        checkOutput("t4_dac_off", {7'd0, dac_on}, 8'd0);
        checkOutput("t4_vol0", {4'd0, volume}, 8'd0);
        applyStimulus(1, 3, 8'h80, 0, 0);
        checkOutput("t4_reload", {7'd0, lfsr_reload}, 8'd1);
        checkOutput("t4_chan_stay", {7'd0, channel_on}, 8'd0);

        // Trigger collides with a length tick while the counter is 0
        applyStimulus(1, 0, 8'h3F, 0, 0);
        applyStimulus(1, 1, 8'hF0, 0, 0);
        applyStimulus(1, 3, 8'h40, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("t5_pre_off", {7'd0, channel_on}, 8'd0);
        applyStimulus(1, 3, 8'hC0, 1, 0);
        checkOutput("t5_chan_on", {7'd0, channel_on}, 8'd1);
        for (int i = 1; i <= 63; i++) begin
            applyStimulus(0, 0, 8'h00, 1, 3'((i % 4) * 2));
        end
        checkOutput("t5_len_64", {7'd0, channel_on}, 8'd1);
        applyStimulus(0, 0, 8'h00, 1, 6);
        checkOutput("t5_len_expire", {7'd0, channel_on}, 8'd0);

        // Reset right after a trigger
        applyStimulus(1, 3, 8'h80, 0, 0);
        checkOutput("t6_trig_reload", {7'd0, lfsr_reload}, 8'd1);
        checkOutput("t6_trig_chan", {7'd0, channel_on}, 8'd1);
        reset = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 0);
        reset = 1'b0;
        checkOutput("t6_rst_reload", {7'd0, lfsr_reload}, 8'd0);
        checkOutput("t6_rst_chan", {7'd0, channel_on}, 8'd0);
        checkOutput("t6_rst_nr43", nr43_q, 8'h00);
        checkOutput("t6_rst_dac", {7'd0, dac_on}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/noise_channel_ctrl.md
Name: noise_channel_ctrl

Overview:
- Control sequencer for the 4-channel audio noise voice.
- Holds the NR41/NR42/NR43/NR44 register state and runs the length counter and volume envelope from frame-sequencer steps.
- Handles trigger events: issues the LFSR reload pulse and drives the channel-enable and volume outputs.
- The noise datapath takes its NR43 configuration and reset/reload strobe from this block; the mixer takes `volume` and `channel_on`.

Parameters:
- LEN_BITS, 6: width of the length counter; full-length reload value is 2^LEN_BITS (64).
- ENV_STEP, 7: frame-sequencer step on which the envelope is clocked.

Ports:
- frequency_timer_clock  in  1  block clock
- reset  in  1  synchronous, active-high reset
- reg_we  in  1  one-cycle register write strobe
- reg_addr  in  2  0=NR41, 1=NR42, 2=NR43, 3=NR44
- reg_wdata  in  8  write data
- frame_tick  in  1  one-cycle strobe per frame-sequencer step
- frame_step  in  3  current step index (0..7), valid with frame_tick
- nr43_q  out  8  latched NR43, to the noise datapath
- lfsr_reload  out  1  one-cycle pulse on trigger
- channel_on  out  1  channel active
- dac_on  out  1  NR42[7:3] != 0
- volume  out  4  current envelope volume (0 when channel_on=0)

Behaviour:
- Clock and reset: reset is reset, synchronous, active-high; clock is frequency_timer_clock.
- Reset values:
  - All registers 0; length counter 0; envelope timer 0.
  - nr43_q=0, lfsr_reload=0, channel_on=0, dac_on=0, volume=0.
  - Reset mid-operation aborts any pending reload pulse.
- Register writes (effective the cycle after reg_we):
  - NR41: length counter = 64 - wdata[5:0].
  - NR42: stored. If wdata[7:3]==0, dac_on=0 and channel_on is cleared the same cycle.
  - NR43: nr43_q = wdata.
  - NR44: stores length_en = wdata[6]. If wdata[7]=1, a trigger occurs.
- Trigger:
  - channel_on = dac_on.
  - If the length counter is 0, load 64.
  - volume = NR42[7:4].
  - env_timer = NR42[2:0].
  - env_active = 1.
  - lfsr_reload=1 for exactly one cycle.
  - A trigger with dac_on=0 still pulses lfsr_reload, and channel_on stays 0.
- Length counter:
  - Decrements when frame_tick=1, frame_step is even, length_en=1 and the counter is nonzero.
  - On the transition to 0, channel_on=0 the following cycle.
  - A counter already at 0 stays 0; no wrap.
- Envelope:
  - Clocked when frame_tick=1, frame_step==ENV_STEP, NR42[2:0]!=0 and env_active=1.
  - env_timer decrements. On reaching 0 it reloads from NR42[2:0] and volume steps by ±1: up if NR42[3]=1, down if NR42[3]=0.
  - If the next step would pass 15 (up) or 0 (down), volume holds and env_active=0 until the next trigger.
  - Period 0: the envelope is frozen.
- Simultaneous events:
  - A register write takes priority over frame_tick in the same cycle for the state it touches: trigger or NR41 write vs length tick → the tick is discarded; trigger or NR42 write vs envelope tick → the tick is discarded.
  - Ticks for untouched state still apply.
- Output rule: volume output = channel_on ? volume_reg : 0.

Optional Feature:
- NOISE_CTRL_STATUS_EN defined: adds output status[7:0] = {channel_on, env_active, length_en, 5'(length counter[4:0])}, registered and updated each cycle.
- Not defined: port absent; no extra logic.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles → all outputs 0; frame_tick pulses cause no change.
2. NR42=0xF0, NR41=0x3E (len 2), NR44=0xC0 → lfsr_reload one pulse, channel_on=1, volume=15. After ticks on steps 0 and 2, channel_on=0 and volume=0.
3. NR42=0x81 (vol 8, down, period 1), trigger → volume 8→7→6… on each step-7 tick; holds at 0 with env_active=0. With NR42=0xF9 (up), volume holds at 15.
4. NR42=0x00 then trigger → lfsr_reload pulses, channel_on=0, dac_on=0. Writing NR42=0x00 while active → channel_on drops the next cycle.
5. Trigger in the same cycle as a frame_tick step 0 with length_en=1 and length 0 → length = 64, not 63.
6. Write NR43=0x5B → nr43_q=0x5B the next cycle. A reset asserted on the cycle after a trigger → lfsr_reload and channel_on both 0.
